sha_digest_unloader: RTL and testbench

Consumer end of the eight hash-word accumulators (H0..H7). When the compression pipeline finishes a block, it presents the final 256-bit digest here. This block snapshots the digest and compares it against a 256-bit mining target one word per cycle. It then streams the eight words out over a 32-bit valid/ready port, reporting whether the digest is strictly below the target.

---
 rtl/sha_digest_unloader.sv | 133 +++++++++++++
 tb/tb_sha_digest_unloader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_digest_unloader.sv
// Snapshots a final SHA-256 digest, checks it against a mining target (strictly below),
// then streams the eight hash words out over a 32-bit valid/ready port.
module sha_digest_unloader #(
    parameter bit STREAM_MISSES = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         digest_valid,
    input  logic [255:0] digest_in,
    input  logic [255:0] target_in,
    output logic         busy,
    output logic         hit,
    output logic         hit_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_word,
    output logic [2:0]   out_index,
    output logic         out_last,
    output logic         overrun
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        STREAM
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [255:0]  digest_q, digest_d;
    logic [255:0]  target_q, target_d;
    logic          decided_q, decided_d;
    logic          lt_q, lt_d;
    logic          hit_q, hit_d;
    logic          hit_valid_q, hit_valid_d;
    logic          overrun_q, overrun_d;

    logic [7:0]    word_sel;
    logic [31:0]   dig_word;
    logic [31:0]   tgt_word;

    // H0 sits in the top bits, so word cnt starts at bit (7-cnt)*32.
    assign word_sel = {~cnt_q, 5'b00000};
    assign dig_word = digest_q[word_sel +: 32];
    assign tgt_word = target_q[word_sel +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            digest_q    <= '0;
            target_q    <= '0;
            decided_q   <= 1'b0;
            lt_q        <= 1'b0;
            hit_q       <= 1'b0;
            hit_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digest_q    <= digest_d;
            target_q    <= target_d;
            decided_q   <= decided_d;
            lt_q        <= lt_d;
            hit_q       <= hit_d;
            hit_valid_q <= hit_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        digest_d    = digest_q;
        target_d    = target_q;
        decided_d   = decided_q;
        lt_d        = lt_q;
        hit_d       = hit_q;
        hit_valid_d = 1'b0;
        overrun_d   = overrun_q | (digest_valid && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (digest_valid) begin
                    digest_d  = digest_in;
                    target_d  = target_in;
                    cnt_d     = 3'd0;
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                // First unequal word (MSW first) decides; all eight words always take a cycle.
                if (!decided_q && (dig_word != tgt_word)) begin
                    decided_d = 1'b1;
                    lt_d      = (dig_word < tgt_word);
                end
                if (cnt_q == 3'd7) begin
                    hit_d       = lt_d;
                    hit_valid_d = 1'b1;
                    cnt_d       = 3'd0;
                    state_d     = (STREAM_MISSES || lt_d) ? STREAM : IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (cnt_q == 3'd7) begin
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == STREAM);
    assign out_word  = out_valid ? dig_word : 32'd0;
    assign out_index = out_valid ? cnt_q : 3'd0;
    assign out_last  = out_valid && (cnt_q == 3'd7);
    assign hit       = hit_q;
    assign hit_valid = hit_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sha_digest_unloader.sv
// Directed and randomized bench for sha_digest_unloader; expected hits and word streams
// come from a 256-bit compare and a word array built from the digest.
module tb_sha_digest_unloader;

    logic         clk;
    logic         rst_n;
    logic         digest_valid;
    logic [255:0] digest_in;
    logic [255:0] target_in;
    logic         out_ready;

    logic         busy, hit, hit_valid, out_valid, out_last, overrun;
    logic [31:0]  out_word;
    logic [2:0]   out_index;

    logic         nm_busy, nm_hit, nm_hit_valid, nm_out_valid, nm_out_last, nm_overrun;
    logic [31:0]  nm_out_word;
    logic [2:0]   nm_out_index;

    int n_checks;
    int n_fail;

    localparam logic [255:0] ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] ONES = {256{1'b1}};

    sha_digest_unloader #(.STREAM_MISSES(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid),
        .digest_in(digest_in), .target_in(target_in),
        .busy(busy), .hit(hit), .hit_valid(hit_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_index(out_index), .out_last(out_last),
        .overrun(overrun)
    );

    sha_digest_unloader #(.STREAM_MISSES(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid),
        .digest_in(digest_in), .target_in(target_in),
        .busy(nm_busy), .hit(nm_hit), .hit_valid(nm_hit_valid),
        .out_valid(nm_out_valid), .out_ready(out_ready),
        .out_word(nm_out_word), .out_index(nm_out_index), .out_last(nm_out_last),
        .overrun(nm_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [255:0] d, input int i);
        return d[255 - 32*i -: 32];
    endfunction

    // One full transaction: ready_mode 0 = always ready, 1 = fixed stall pattern, 2 = random.
    task automatic applyStimulus(input string name, input logic [255:0] d, input logic [255:0] t,
                                 input int ready_mode, input bit ovr);
        logic [31:0] exp_words [8];
        int          pat [64];
        int          fixed_pat [15];
        bit          exp_hit;
        int          exp_cycles;
        int          ones;
        int          cycles;
        int          transfers;
        bit          early_bad;
        bit          prev_stall;
        logic [31:0] prev_word;
        logic [2:0]  prev_idx;

        fixed_pat = '{1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 1};
        exp_hit = (d < t);
        for (int i = 0; i < 8; i++) exp_words[i] = word_of(d, i);
        for (int i = 0; i < 64; i++) begin
            if (ready_mode == 0) pat[i] = 1;
            else if (ready_mode == 1) pat[i] = (i < 15) ? fixed_pat[i] : 1;
            else pat[i] = (i < 40) ? int'($urandom_range(0, 1)) : 1;
        end
        ones = 0;
        exp_cycles = 0;
        for (int i = 0; i < 64; i++) begin
            if (ones < 8 && pat[i] == 1) begin
                ones++;
                if (ones == 8) exp_cycles = i + 1;
            end
        end

        out_ready    = 1'b0;
        digest_in    = d;
        target_in    = t;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        checkOutput({name, ".busy_after_E0"}, busy, 1);

        early_bad = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (ovr && k == 4) begin
                digest_valid = 1'b1;
                digest_in    = ~d;
                target_in    = ~t;
            end
            tick();
            digest_valid = 1'b0;
            if (k < 8 && (hit_valid || out_valid)) early_bad = 1'b1;
        end
        checkOutput({name, ".no_early_result"}, early_bad, 0);
        checkOutput({name, ".hit_valid"}, hit_valid, 1);
        checkOutput({name, ".hit"}, hit, exp_hit);
        checkOutput({name, ".stream_start"}, {out_valid, out_index}, {1'b1, 3'd0});

        cycles     = 0;
        transfers  = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
        prev_idx   = '0;
        while (busy && cycles < 200) begin
            out_ready = pat[cycles % 64][0];
            if (prev_stall) begin
                checkOutput({name, ".stall_word"}, out_word, prev_word);
                checkOutput({name, ".stall_index"}, out_index, prev_idx);
            end
            if (out_valid && out_ready) begin
                checkOutput({name, ".word"}, out_word, exp_words[transfers % 8]);
                checkOutput({name, ".index"}, out_index, transfers[2:0]);
                checkOutput({name, ".last"}, out_last, transfers == 7);
                if (ovr && transfers == 7) begin
                    digest_valid = 1'b1;
                    digest_in    = ~d;
                end
                transfers++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = out_word;
            prev_idx   = out_index;
            tick();
            digest_valid = 1'b0;
            cycles++;
            if (cycles == 1) checkOutput({name, ".hit_valid_one_cycle"}, hit_valid, 0);
        end
        out_ready = 1'b0;
        checkOutput({name, ".transfers"}, transfers, 8);
        checkOutput({name, ".stream_cycles"}, cycles, exp_cycles);
        checkOutput({name, ".idle_outputs"}, {busy, out_valid, out_last, out_index, out_word},
                    '0);
        checkOutput({name, ".hit_held"}, hit, exp_hit);
    endtask

    initial begin
        logic [255:0] d;
        logic [255:0] t;
        bit           nm_ov_seen;
        int           w;

        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        digest_valid = 1'b0;
        digest_in    = '0;
        target_in    = '0;
        out_ready    = 1'b0;

        #12;
        checkOutput("reset.outputs",
                    {busy, hit, hit_valid, out_valid, out_word, out_index, out_last, overrun}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        $display("[TB] abc vs all-ones target, always ready");
        applyStimulus("abc", ABC, ONES, 0, 1'b0);

        applyStimulus("equal", ABC, ABC, 0, 1'b0);
        t = ABC;
        t[31:0] = 32'hf20015ae;
        applyStimulus("last_word", ABC, t, 0, 1'b0);
        t = {32'hba7816be, {224{1'b1}}};
        applyStimulus("first_word", ABC, t, 0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus("backpressure", ABC, ONES, 1, 1'b0);

        $display("[TB] STREAM_MISSES=0 miss");
        digest_in    = ABC;
        target_in    = '0;
        out_ready    = 1'b1;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        nm_ov_seen   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            nm_ov_seen |= nm_out_valid;
            if (k == 7) checkOutput("nomiss.busy_E7", {nm_busy, nm_hit_valid}, {1'b1, 1'b0});
        end
        checkOutput("nomiss.hit_valid", nm_hit_valid, 1);
        checkOutput("nomiss.hit", nm_hit, 0);
        checkOutput("nomiss.busy_low", nm_busy, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            nm_ov_seen |= nm_out_valid;
            if (k == 0) checkOutput("nomiss.hit_valid_one_cycle", nm_hit_valid, 0);
        end
        checkOutput("nomiss.never_valid", nm_ov_seen, 0);
        out_ready = 1'b0;
        checkOutput("default_inst_done", busy, 0);

        $display("[TB] overrun");
        checkOutput("overrun.before", overrun, 0);
        applyStimulus("overrun", ABC, ONES, 0, 1'b1);
        checkOutput("overrun.set", overrun, 1);
        tick();
        checkOutput("overrun.ignored_final", busy, 0);

        $display("[TB] randomized digests");
        for (int r = 0; r < 6; r++) begin
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (r % 3 == 1) begin
                t = d;
                w = int'($urandom_range(0, 7));
                t[255 - 32*w -: 32] = d[255 - 32*w -: 32] + ((r % 2 == 0) ? 32'd1 : 32'hffffffff);
            end else if (r % 3 == 2) begin
                t = d;
            end
            applyStimulus("random", d, t, 2, 1'b0);
        end
        checkOutput("overrun.sticky", overrun, 1);

        $display("[TB] async reset mid-stream");
        digest_in    = ABC;
        target_in    = ONES;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checkOutput("midreset.at_index3", {out_valid, out_index}, {1'b1, 3'd3});
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset.outputs",
                    {busy, hit, hit_valid, out_valid, out_word, out_index, out_last, overrun}, '0);
        out_ready = 1'b0;
        tick();
        checkOutput("midreset.no_hit_valid", hit_valid, 0);
        rst_n = 1'b1;
        tick();
        applyStimulus("after_reset", ABC, ONES, 0, 1'b0);
        checkOutput("after_reset.overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
